// File: rtl/symbol_range_lookup_pkg.sv
// Shared constants and types for the symbol -> cumulative-range lookup block.
// Used by the top level, the inverse-map storage and the bus interface.
package symbol_range_pkg;

  localparam int DEPTH   = 256;             // table entries
  localparam int IDX_W   = $clog2(DEPTH);   // table index width (8)
  localparam int SYM_W   = 8;               // symbol code width
  localparam int RANGE_W = 16;              // cumulative range width
  localparam int SYMS    = 2 ** SYM_W;      // inverse-map entries, one per symbol code

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [SYM_W-1:0]   sym_t;
  typedef logic [RANGE_W-1:0] range_t;

  typedef enum logic [1:0] {
    LOAD,   // tables writable, lookups answered with errors
    BUILD,  // walking the symbol table to fill the inverse map
    READY   // inverse map valid, lookups served
  } state_e;

  // One lookup in flight.
  //   valid : a request occupies this stage
  //   req   : the request arrived while the block was ready (otherwise it is
  //           answered with an error)
  //   sym   : requested symbol code
  //   idx   : table index the inverse map returned for sym
  //   hit   : the inverse map holds an entry for sym
  typedef struct packed {
    logic valid;
    logic req;
    sym_t sym;
    idx_t idx;
    logic hit;
  } stage_t;

  // A usable interval must have a non-zero width; compared unsigned.
  function automatic logic interval_ok(input range_t low, input range_t high);
    return high > low;
  endfunction

endpackage

// File: rtl/symbol_range_lookup_if.sv
// Bus bundle for symbol_range_lookup: table load port, lookup request port
// and result/status outputs. The block itself uses the slave modport; the
// agent driving loads and lookups uses the master modport.
//   load_en/load_addr/load_range/load_symbol : write one table entry
//   load_done                                : start the inverse-map build
//   lookup_en/symbol_code                    : lookup request
//   range_low/range_high                     : interval [low, high)
//   lookup_valid/lookup_error                : one-cycle result strobes
//   ready                                    : lookups are being served
//   table_error                              : sticky duplicate-symbol flag
interface symbol_range_lookup_if;
  import symbol_range_pkg::*;

  logic   load_en;
  idx_t   load_addr;
  range_t load_range;
  sym_t   load_symbol;
  logic   load_done;
  logic   lookup_en;
  sym_t   symbol_code;

  range_t range_low;
  range_t range_high;
  logic   lookup_valid;
  logic   lookup_error;
  logic   ready;
  logic   table_error;

  modport master (
    output load_en, load_addr, load_range, load_symbol, load_done,
    output lookup_en, symbol_code,
    input  range_low, range_high, lookup_valid, lookup_error, ready, table_error
  );

  modport slave (
    input  load_en, load_addr, load_range, load_symbol, load_done,
    input  lookup_en, symbol_code,
    output range_low, range_high, lookup_valid, lookup_error, ready, table_error
  );

endinterface

// File: rtl/symbol_range_lookup_inverse_map.sv
// Symbol -> table-index inverse map: one {valid, idx} entry per symbol code.
// Ports:
//   clk      : clock
//   clear    : drop every valid bit in one cycle
//   wr_en    : write wr_idx for symbol wr_sym and mark it valid
//   wr_sym   : symbol being mapped
//   wr_idx   : table index recorded for wr_sym
//   rd_sym   : symbol to look up (combinational read)
//   rd_valid : an entry exists for rd_sym
//   rd_idx   : recorded index for rd_sym (meaningful only when rd_valid)
module symbol_inverse_map
  import symbol_range_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic wr_en,
  input  sym_t wr_sym,
  input  idx_t wr_idx,
  input  sym_t rd_sym,
  output logic rd_valid,
  output idx_t rd_idx
);

  // Valid bits live in flops so the whole map can be invalidated at once.
  logic [SYMS-1:0] valid_q;
  idx_t            idx_mem [SYMS];

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // design samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_sym] <= 1'b1;
    end
  end

  // NOTE: the index array has no reset; it is only read where its valid bit
  // is set, and the valid bits are defined by the bulk clear before use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      idx_mem[wr_sym] <= wr_idx;
    end
  end

  assign rd_valid = valid_q[rd_sym];
  assign rd_idx   = idx_mem[rd_sym];

endmodule

// File: rtl/symbol_range_lookup.sv
// Encoder-side symbol -> [range_low, range_high) lookup.
// Holds the range/symbol table pair, builds a symbol -> index inverse map
// after the tables are loaded, then serves lookups through a two-stage
// pipeline at one symbol per cycle.
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous active-high reset
//   bus   : symbol_range_lookup_if.slave (load port, lookup port, results)
module symbol_range_lookup
  import symbol_range_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  symbol_range_lookup_if.slave        bus
);

  // Tables keep their contents across reset; only a new load changes them.
  range_t range_table  [DEPTH];
  sym_t   symbol_table [DEPTH];

  state_e state_q, state_d;
  idx_t   build_idx_q;
  logic   ready_q;
  logic   table_error_q;

  // FSM decode outputs
  logic table_wr;     // write the load port into the tables this cycle
  logic start_build;  // load_done accepted: clear map, restart build index
  logic build_step;   // process symbol_table[build_idx_q] this cycle
  logic flush;        // reload from READY: drop lookups still in flight

  // Inverse map port signals
  sym_t map_rd_sym;
  logic map_rd_valid;
  idx_t map_rd_idx;
  logic map_clear;
  logic map_wr_en;

  // Lookup pipeline
  stage_t s1_q, s2_q;
  range_t s2_low, s2_high;
  logic   s2_ok;

  range_t range_low_q, range_high_q;
  logic   lookup_valid_q, lookup_error_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    table_wr    = 1'b0;
    start_build = 1'b0;
    build_step  = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      LOAD: begin
        // A write on the same cycle as load_done lands before the build
        // reads the table, so the build sees that entry.
        table_wr = bus.load_en;
        if (bus.load_done) begin
          start_build = 1'b1;
          state_d     = BUILD;
        end
      end
      BUILD: begin
        build_step = 1'b1;
        if (build_idx_q == idx_t'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (bus.load_en) begin
          table_wr = 1'b1;
          flush    = 1'b1;
          state_d  = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tables
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (table_wr && !reset) begin
      range_table[bus.load_addr]  <= bus.load_range;
      symbol_table[bus.load_addr] <= bus.load_symbol;
    end
  end

  // ---------------------------------------------------------------------------
  // Inverse map. Its single read port is shared: the build walk uses it while
  // in BUILD, lookups use it otherwise (lookups in BUILD are errors anyway).
  // ---------------------------------------------------------------------------
  assign map_rd_sym = (state_q == BUILD) ? symbol_table[build_idx_q] : bus.symbol_code;
  assign map_clear  = start_build && !reset;
  // First occurrence of a symbol wins; later duplicates only raise table_error.
  assign map_wr_en  = build_step && !map_rd_valid && !reset;

  symbol_inverse_map u_inverse_map (
    .clk      (clk),
    .clear    (map_clear),
    .wr_en    (map_wr_en),
    .wr_sym   (map_rd_sym),
    .wr_idx   (build_idx_q),
    .rd_sym   (map_rd_sym),
    .rd_valid (map_rd_valid),
    .rd_idx   (map_rd_idx)
  );

  // ---------------------------------------------------------------------------
  // Build counter, duplicate detection, ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      build_idx_q   <= '0;
      table_error_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      if (start_build) begin
        build_idx_q   <= '0;
        table_error_q <= 1'b0;
      end else if (build_step) begin
        build_idx_q <= build_idx_q + idx_t'(1);
        if (map_rd_valid) begin
          table_error_q <= 1'b1;
        end
      end
      // ready trails the READY state by one cycle and drops as soon as a
      // reload is accepted; while ready_q is set the state is READY.
      ready_q <= (state_q == READY) && !bus.load_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup pipeline
  //   stage 1: capture the request and the inverse-map result
  //   stage 2: hold it one more cycle
  //   output : read range_table at idx and idx-1, register the strobes
  // A reload from READY drops both in-flight stages.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q.valid <= bus.lookup_en && !flush;
      s1_q.req   <= ready_q;
      s1_q.sym   <= bus.symbol_code;
      s1_q.idx   <= map_rd_idx;
      s1_q.hit   <= map_rd_valid;
      s2_q       <= s1_q;
      if (flush) begin
        s2_q.valid <= 1'b0;
      end
    end
  end

  always_comb begin
    s2_high = range_table[s2_q.idx];
    s2_low  = '0;
    if (s2_q.idx != '0) begin
      s2_low = range_table[s2_q.idx - idx_t'(1)];
    end
    // The symbol-table cross-check guards against a stale map entry; after a
    // completed build it always agrees.
    s2_ok = s2_q.req && s2_q.hit
         && (symbol_table[s2_q.idx] == s2_q.sym)
         && interval_ok(s2_low, s2_high);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      range_low_q    <= '0;
      range_high_q   <= '0;
      lookup_valid_q <= 1'b0;
      lookup_error_q <= 1'b0;
    end else begin
      lookup_valid_q <= 1'b0;
      lookup_error_q <= 1'b0;
      if (s2_q.valid) begin
        if (s2_ok) begin
          lookup_valid_q <= 1'b1;
          range_low_q    <= s2_low;
          range_high_q   <= s2_high;
        end else begin
          // Not ready, unmapped symbol or zero-width interval; the range
          // outputs keep their previous value.
          lookup_error_q <= 1'b1;
        end
      end
    end
  end

  assign bus.range_low    = range_low_q;
  assign bus.range_high   = range_high_q;
  assign bus.lookup_valid = lookup_valid_q;
  assign bus.lookup_error = lookup_error_q;
  assign bus.ready        = ready_q;
  assign bus.table_error  = table_error_q;

endmodule

// File: tb/tb_symbol_range_lookup.sv
// Scoreboard bench for symbol_range_lookup: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_symbol_range_lookup;
  import symbol_range_pkg::*;

  logic clk = 1'b0;
  logic reset;

  symbol_range_lookup_if bus();

  symbol_range_lookup dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit     err;
    range_t lo;
    range_t hi;
    int     due;
    sym_t   sym;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input sym_t s, input bit err, input range_t lo, input range_t hi);
    exp_t e;
    e.err = err;
    e.lo  = lo;
    e.hi  = hi;
    e.due = cyc + 3;
    e.sym = s;
    sb.push_back(e);
  endtask

  // Monitor: strobes are sampled on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      check($sformatf("missing_strobe sym=%0h", mon_e.sym), 32'd0, 32'd1);
    end
    if (bus.lookup_valid || bus.lookup_error) begin
      check("strobe_exclusive", 32'(bus.lookup_valid & bus.lookup_error), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("latency sym=%0h", mon_e.sym), 32'(cyc), 32'(mon_e.due));
        check($sformatf("error_flag sym=%0h", mon_e.sym), 32'(bus.lookup_error), 32'(mon_e.err));
        if (!mon_e.err) begin
          check($sformatf("range_low sym=%0h", mon_e.sym), 32'(bus.range_low), 32'(mon_e.lo));
          check($sformatf("range_high sym=%0h", mon_e.sym), 32'(bus.range_high), 32'(mon_e.hi));
        end
      end
    end
  end

  // All drivers below are entered right after a falling edge and leave right
  // after a later one.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_entry(input idx_t a, input sym_t s, input range_t r);
    bus.load_en     = 1'b1;
    bus.load_addr   = a;
    bus.load_symbol = s;
    bus.load_range  = r;
    tick();
    bus.load_en = 1'b0;
  endtask

  task automatic lookup(input sym_t s, input bit err, input range_t lo, input range_t hi);
    push_exp(s, err, lo, hi);
    bus.lookup_en   = 1'b1;
    bus.symbol_code = s;
    tick();
    bus.lookup_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_range_low"},    32'(bus.range_low),    32'd0);
    check({tag, "_range_high"},   32'(bus.range_high),   32'd0);
    check({tag, "_lookup_valid"}, 32'(bus.lookup_valid), 32'd0);
    check({tag, "_lookup_error"}, 32'(bus.lookup_error), 32'd0);
    check({tag, "_ready"},        32'(bus.ready),        32'd0);
    check({tag, "_table_error"},  32'(bus.table_error),  32'd0);
  endtask

  // Pulse load_done (optionally with a table write) and count edges until
  // ready; ready must first appear after the 257th edge following load_done.
  // With probe set, a lookup is issued mid-build and must come back an error.
  task automatic build_and_wait(input bit wr, input idx_t a, input sym_t s, input range_t r,
                                input bit probe, input sym_t probe_sym);
    int seen_at;
    seen_at = 401;
    bus.load_done   = 1'b1;
    bus.load_en     = wr;
    bus.load_addr   = a;
    bus.load_symbol = s;
    bus.load_range  = r;
    tick();
    bus.load_done = 1'b0;
    bus.load_en   = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (probe && k == 20) begin
        check("ready_during_build", 32'(bus.ready), 32'd0);
        push_exp(probe_sym, 1'b1, '0, '0);
        bus.lookup_en   = 1'b1;
        bus.symbol_code = probe_sym;
      end
      tick();
      bus.lookup_en = 1'b0;
      if (bus.ready) begin
        seen_at = k;
        break;
      end
    end
    check("load_to_ready_edges", 32'(seen_at), 32'd257);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load_en     = 1'b0;
    bus.load_addr   = '0;
    bus.load_range  = '0;
    bus.load_symbol = '0;
    bus.load_done   = 1'b0;
    bus.lookup_en   = 1'b0;
    bus.symbol_code = '0;
    reset           = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_outputs_zero("reset");

    // Identity tables; the last entry shares its cycle with load_done.
    for (int i = 0; i < 255; i++) begin
      write_entry(idx_t'(i), sym_t'(i), range_t'(4 * (i + 1)));
    end
    build_and_wait(1'b1, 8'd255, 8'd255, 16'd1024, 1'b0, 8'd0);
    check("table_error_identity", 32'(bus.table_error), 32'd0);

    lookup(8'd0,  1'b0, 16'd0,  16'd4);
    lookup(8'd10, 1'b0, 16'd40, 16'd44);
    for (int i = 255; i >= 0; i--) begin
      lookup(sym_t'(i), 1'b0, range_t'(4 * i), range_t'(4 * i + 4));
    end
    repeat (4) tick();

    // Lookup followed by a reload on the next cycle: that lookup is dropped.
    bus.lookup_en   = 1'b1;
    bus.symbol_code = 8'd10;
    tick();
    bus.lookup_en = 1'b0;
    write_entry(8'd5, 8'h33, 16'd24);
    check("ready_after_reload", 32'(bus.ready), 32'd0);
    repeat (3) tick();
    lookup(8'h40, 1'b1, '0, '0);

    // Duplicate 0x33 at 5 and 9 (51 also holds 0x33); entry 7 zero width.
    write_entry(8'd9, 8'h33, 16'd40);
    write_entry(8'd7, 8'd7,  16'd28);
    build_and_wait(1'b0, '0, '0, '0, 1'b1, 8'h33);
    check("table_error_dup", 32'(bus.table_error), 32'd1);

    lookup(8'h33, 1'b0, 16'd20,   16'd24);
    lookup(8'd5,  1'b1, '0,       '0);
    lookup(8'd9,  1'b1, '0,       '0);
    lookup(8'd7,  1'b1, '0,       '0);
    lookup(8'd8,  1'b0, 16'd28,   16'd36);
    lookup(8'd6,  1'b0, 16'd24,   16'd28);
    lookup(8'd10, 1'b0, 16'd40,   16'd44);
    lookup(8'd255, 1'b0, 16'd1020, 16'd1024);
    repeat (4) tick();

    // Reset part-way through a build.
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    repeat (99) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs_zero("mid_build_reset");
    build_and_wait(1'b0, '0, '0, '0, 1'b0, 8'd0);
    check("table_error_rebuild", 32'(bus.table_error), 32'd1);
    lookup(8'h33, 1'b0, 16'd20,  16'd24);
    lookup(8'd100, 1'b0, 16'd400, 16'd404);

    repeat (6) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
